ram_fifo_ctrl: RTL and testbench

//  FIFO controller that sits directly upstream of the team's 32x4 dual-port distributed RAM.

---
 rtl/ram_fifo_ctrl_pkg.sv | 18 +
 rtl/ram_fifo_ctrl_ptr.sv | 30 +++
 rtl/ram_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_ram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing for the FIFO controller and its 32x4 dual-port distributed RAM,
// so both sides of the RAM interface stay width-consistent.
package ram_fifo_ctrl_pkg;

    localparam int FIFO_DW       = 4;
    localparam int FIFO_AW       = 5;
    localparam int FIFO_DEPTH    = 32;
    localparam int FIFO_AF_LEVEL = 28;
    localparam int FIFO_AE_LEVEL = 4;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/ram_fifo_ctrl_ptr.sv
// Wrapping FIFO pointer: W bits, MSB is the wrap bit; increment enable,
// synchronous clear and asynchronous active-low reset.
module fifo_ptr #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register; natural binary wrap flips the MSB on every lap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (clr) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port distributed RAM: port-A writes,
// port-B asynchronous reads, occupancy, flags and peak-occupancy watermark.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DW       = FIFO_DW,
    parameter int AW       = FIFO_AW,
    parameter int AF_LEVEL = FIFO_AF_LEVEL,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   peak,
    output logic          ram_we,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_dpra,
    input  logic [DW-1:0] ram_dpo
);

    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic [AW:0] wr_ptr_s;
    logic [AW:0] rd_ptr_s;
    logic [AW:0] count_r;
    logic [AW:0] count_nxt_s;
    logic [AW:0] peak_r;
    logic [AW:0] peak_nxt_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    fifo_op_e    op_s;

    fifo_ptr #(.W(AW+1)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push_s),
        .ptr   (wr_ptr_s)
    );

    fifo_ptr #(.W(AW+1)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop_s),
        .ptr   (rd_ptr_s)
    );

    assign empty_s = (wr_ptr_s == rd_ptr_s);
    assign full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) && (wr_ptr_s[AW] != rd_ptr_s[AW]);

    // rst_n gates the handshakes so the RAM never sees a write while reset is held.
    assign push_s = wr_valid & ~full_s  & ~flush & rst_n;
    assign pop_s  = rd_ready & ~empty_s & ~flush & rst_n;
    assign op_s   = fifo_op_e'({push_s, pop_s});

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = '0;
        end else begin
            case (op_s)
                OP_PUSH: count_nxt_s = count_r + (AW+1)'(1);
                OP_POP:  count_nxt_s = count_r - (AW+1)'(1);
                OP_BOTH: count_nxt_s = count_r;
                OP_IDLE: count_nxt_s = count_r;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Watermark tracks the highest occupancy the next cycle will show.
    always_comb begin
        peak_nxt_s = peak_r;
        if (flush) begin
            peak_nxt_s = '0;
        end else if (count_nxt_s > peak_r) begin
            peak_nxt_s = count_nxt_s;
        end else begin
            peak_nxt_s = peak_r;
        end
    end

    // Occupancy and watermark registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            peak_r  <= '0;
        end else begin
            count_r <= count_nxt_s;
            peak_r  <= peak_nxt_s;
        end
    end

    assign count        = count_r;
    assign peak         = peak_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign wr_ready     = ~full_s;
    assign rd_valid     = ~empty_s;
    assign almost_full  = (count_r >= AF_THR);
    assign almost_empty = (count_r <= AE_THR);

    assign ram_we   = push_s;
    assign ram_a    = wr_ptr_s[AW-1:0];
    assign ram_di   = wr_data;
    assign ram_dpra = rd_ptr_s[AW-1:0];
    assign rd_data  = ram_dpo;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 32x4 dual-port RAM,
// table-driven vectors plus a data scoreboard queue.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] peak;
    logic       ram_we;
    logic [4:0] ram_a;
    logic [3:0] ram_di;
    logic [4:0] ram_dpra;
    logic [3:0] ram_dpo;

    logic [3:0] mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
    end
    assign ram_dpo = mem[ram_dpra];

    ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .peak         (peak),
        .ram_we       (ram_we),
        .ram_a        (ram_a),
        .ram_di       (ram_di),
        .ram_dpra     (ram_dpra),
        .ram_dpo      (ram_dpo)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] sb_q[$];
    int         m_cnt;
    int         m_peak;
    logic [4:0] m_wp;
    logic [4:0] m_rp;
    logic       s_we;
    logic [4:0] s_a;

    typedef struct {
        logic       wv;
        logic [3:0] wd;
        logic       rr;
        logic       fl;
        logic       exp_we;
        logic [4:0] exp_a;
        logic [5:0] exp_cnt;
        logic       exp_rv;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive, check the combinational side, update the model, check state.
    task automatic step(input logic wv, input logic [3:0] wd, input logic rr, input logic fl);
        logic m_push;
        logic m_pop;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        m_push = wv && !fl && (m_cnt < 32);
        m_pop  = rr && !fl && (m_cnt > 0);
        s_we = ram_we;
        s_a  = ram_a;
        chk("ram_we", 32'(ram_we), 32'(m_push));
        if (m_push) chk("ram_a", 32'(ram_a), 32'(m_wp));
        if (m_pop) begin
            chk("ram_dpra", 32'(ram_dpra), 32'(m_rp));
            if (sb_q.size() > 0) begin
                chk("rd_data", 32'(rd_data), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
        end
        if (fl) begin
            sb_q.delete();
            m_cnt = 0;
            m_peak = 0;
            m_wp = 5'd0;
            m_rp = 5'd0;
        end else begin
            if (m_push) begin
                sb_q.push_back(wd);
                m_wp = m_wp + 5'd1;
            end
            if (m_pop) m_rp = m_rp + 5'd1;
            m_cnt = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
            if (m_cnt > m_peak) m_peak = m_cnt;
        end
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("peak", 32'(peak), 32'(m_peak));
        chk("full", 32'(full), 32'(m_cnt == 32));
        chk("empty", 32'(empty), 32'(m_cnt == 0));
        chk("wr_ready", 32'(wr_ready), 32'(m_cnt != 32));
        chk("rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= 28));
        chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_peak"}, 32'(peak), 32'd0);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wr_valid = 1'b1;
        wr_data = 4'h0;
        rd_ready = 1'b0;
        m_cnt = 0;
        m_peak = 0;
        m_wp = 5'd0;
        m_rp = 5'd0;

        vecs[0] = '{wv:1'b1, wd:4'hA, rr:1'b0, fl:1'b0, exp_we:1'b1, exp_a:5'd0, exp_cnt:6'd1, exp_rv:1'b1};
        vecs[1] = '{wv:1'b1, wd:4'hC, rr:1'b0, fl:1'b0, exp_we:1'b1, exp_a:5'd1, exp_cnt:6'd2, exp_rv:1'b1};
        vecs[2] = '{wv:1'b0, wd:4'h0, rr:1'b1, fl:1'b0, exp_we:1'b0, exp_a:5'd2, exp_cnt:6'd1, exp_rv:1'b1};
        vecs[3] = '{wv:1'b0, wd:4'h0, rr:1'b1, fl:1'b0, exp_we:1'b0, exp_a:5'd2, exp_cnt:6'd0, exp_rv:1'b0};

        // 1. reset held two cycles, wr_valid high to prove no write while in reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        wr_valid = 1'b0;

        // 2. table-driven push A, push C, pop, pop
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl);
            chk($sformatf("vec%0d_we", i), 32'(s_we), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_a", i), 32'(s_a), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
            if (i == 2) chk("head_after_pop", 32'(rd_data), 32'h0000000C);
        end

        // 3. fill to full with 0..F,0..F, then a blocked 33rd write
        for (int i = 0; i < 32; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_peak", 32'(peak), 32'd32);
        step(1'b1, 4'h5, 1'b0, 1'b0);
        chk("blocked_we", 32'(s_we), 32'd0);

        // 4. full with push+pop: pop only, then push accepted, then drain across wrap
        step(1'b1, 4'h7, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(count), 32'd31);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        chk("refill_count", 32'(count), 32'd32);
        for (int i = 0; i < 32; i++) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("drained_empty", 32'(empty), 32'd1);

        // 5. count=5 then simultaneous push/pop for 40 cycles
        for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom_range(15, 0)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 4'($urandom_range(15, 0)), 1'b1, 1'b0);
        chk("steady_count", 32'(count), 32'd5);

        // 6. count=10, flush with wr_valid, then reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 3), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd10);
        step(1'b1, 4'h3, 1'b0, 1'b1);
        chk("flush_we", 32'(s_we), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_peak", 32'(peak), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 8), 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data = 4'hE;
        flush = 1'b0;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        m_cnt = 0;
        m_peak = 0;
        m_wp = 5'd0;
        m_rp = 5'd0;
        step(1'b1, 4'h6, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
